// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer serial front end.
package accel_pkg;

  localparam int unsigned ACCEL_W = 14;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_st_e;
  typedef enum logic [1:0] {HUNT, HI, LO} byte_st_e;

endpackage

// File: rtl/accel_frm_rx_if.sv
// Bus between the accelerometer front end (master) and its UART line / sample consumer (slave).
interface accel_frm_rx_if;
  import accel_pkg::*;

  logic               RX_A;
  logic [ACCEL_W-1:0] accel_data;
  logic               accel_vld;
  logic               frm_err;
  logic               rx_busy;

  modport master (input RX_A, output accel_data, accel_vld, frm_err, rx_busy);
  modport slave (output RX_A, input accel_data, accel_vld, frm_err, rx_busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchronizer, bit FSM and down-counting baud timer.
module uart_rx_byte
  import accel_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_rdy,
  output logic       stop_err,
  output logic       busy
);

  // Reload with BAUD_DIV-1 so that expiries are spaced exactly BAUD_DIV cycles apart.
  localparam logic [15:0] HalfCnt = 16'(BAUD_DIV / 2);
  localparam logic [15:0] FullCnt = 16'(BAUD_DIV - 1);

  logic       rx_meta, rx_s, rx_prev;
  bit_st_e    state;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       expiry;

  assign expiry = (cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      state   <= IDLE;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      unique case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            cnt   <= HalfCnt;
          end
        end
        START: begin
          if (!expiry) begin
            cnt <= cnt - 16'd1;
          end else if (!rx_s) begin
            state   <= DATA;
            cnt     <= FullCnt;
            bit_idx <= 3'd0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!expiry) begin
            cnt <= cnt - 16'd1;
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= FullCnt;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (!expiry) cnt <= cnt - 16'd1;
          else         state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded in the stop-sample cycle so the consumer can register on the same edge.
  assign byte_rdy = (state == STOP) && expiry && rx_s;
  assign stop_err = (state == STOP) && expiry && !rx_s;
  assign rx_byte  = shreg;
  assign busy     = (state != IDLE);

endmodule

// File: rtl/accel_frm_rx.sv
// Accelerometer frame receiver: HDR, HI, LO bytes -> signed 14-bit sample.
// Optional inter-byte timeout enabled by defining ACCEL_FRM_TMO_EN.
module accel_frm_rx
  import accel_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEF,
  parameter int unsigned TMO_BITS = 20
) (
  input logic            clk,
  input logic            rst,
  accel_frm_rx_if.master bus
);

  logic [7:0] rx_byte;
  logic       byte_rdy, stop_err, busy;

  uart_rx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .rx      (bus.RX_A),
    .rx_byte (rx_byte),
    .byte_rdy(byte_rdy),
    .stop_err(stop_err),
    .busy    (busy)
  );

  byte_st_e           st;
  logic [5:0]         hi_q;
  logic [ACCEL_W-1:0] data_q;
  logic               vld_q, err_q;
  logic               tmo_hit;

`ifdef ACCEL_FRM_TMO_EN
  localparam int unsigned TmoLimit = TMO_BITS * BAUD_DIV;
  logic [31:0] tmo_cnt;

  // Only idle gaps inside a partial frame are timed.
  assign tmo_hit = (st != HUNT) && !busy && (tmo_cnt == 32'(TmoLimit - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 32'd0;
    end else if (st == HUNT || busy || tmo_hit) begin
      tmo_cnt <= 32'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  logic unused_tmo_bits;
  assign unused_tmo_bits = ^TMO_BITS;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= HUNT;
      hi_q   <= 6'd0;
      data_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      if (stop_err) begin
        err_q <= 1'b1;
        st    <= HUNT;
      end else if (byte_rdy) begin
        unique case (st)
          HUNT: if (rx_byte == HDR_BYTE) st <= HI;
          HI: begin
            hi_q <= rx_byte[5:0];
            if (rx_byte[7:6] != 2'b00) begin
              err_q <= 1'b1;
              st    <= HUNT;
            end else begin
              st <= LO;
            end
          end
          LO: begin
            data_q <= {hi_q, rx_byte};
            vld_q  <= 1'b1;
            st     <= HUNT;
          end
          default: st <= HUNT;
        endcase
      end else if (tmo_hit) begin
        err_q <= 1'b1;
        st    <= HUNT;
      end
    end
  end

  assign bus.accel_data = data_q;
  assign bus.accel_vld  = vld_q;
  assign bus.frm_err    = err_q;
  assign bus.rx_busy    = busy;

endmodule

// File: tb/tb_accel_frm_rx.sv
// Directed self-checking bench for accel_frm_rx with BAUD_DIV=16.
// Covers the ACCEL_FRM_TMO_EN build as well when that macro is defined.
module tb_accel_frm_rx;
  localparam int unsigned Bd = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accel_frm_rx_if bus ();

  accel_frm_rx #(
    .BAUD_DIV(Bd),
    .HDR_BYTE(8'hA5),
    .TMO_BITS(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int bad_data_cnt = 0;
  int last_vld_cyc = 0;
  int prev_vld_cyc = 0;
  logic [13:0] prev_data = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      prev_data = bus.accel_data;
    end else begin
      if (bus.accel_vld) begin
        vld_cnt++;
        prev_vld_cyc = last_vld_cyc;
        last_vld_cyc = cyc;
      end else if (bus.accel_data !== prev_data) begin
        bad_data_cnt++;
      end
      if (bus.frm_err) err_cnt++;
      prev_data = bus.accel_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.RX_A = 1'b0;
    repeat (Bd) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX_A = b[i];
      repeat (Bd) @(negedge clk);
    end
    bus.RX_A = stop_bit;
    repeat (Bd) @(negedge clk);
    bus.RX_A = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b);
    send_byte(h, 1'b1);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
  endtask

  initial begin
    int err_base;
    bus.RX_A = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(bus.accel_data), 32'h0);
    check("rst_vld", 32'(bus.accel_vld), 32'h0);
    check("rst_err", 32'(bus.frm_err), 32'h0);
    check("rst_busy", 32'(bus.rx_busy), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame, max positive sample.
    send_frame(8'hA5, 8'h1F, 8'hFF);
    repeat (20) @(negedge clk);
    check("f1_vld", 32'(vld_cnt), 32'd1);
    check("f1_data", 32'(bus.accel_data), 32'h1FFF);
    check("f1_err", 32'(err_cnt), 32'd0);

    // Back-to-back frames: most negative, then -1; pulse spacing is one full frame.
    send_frame(8'hA5, 8'h20, 8'h00);
    check("f2_data", 32'(bus.accel_data), 32'h2000);
    send_frame(8'hA5, 8'h3F, 8'hFF);
    repeat (20) @(negedge clk);
    check("f3_vld", 32'(vld_cnt), 32'd3);
    check("f3_data", 32'(bus.accel_data), 32'h3FFF);
    check("f3_spacing", 32'(last_vld_cyc - prev_vld_cyc), 32'd480);

    // Junk before the header is skipped silently.
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_frame(8'hA5, 8'h01, 8'h02);
    repeat (20) @(negedge clk);
    check("hunt_err", 32'(err_cnt), 32'd0);
    check("hunt_vld", 32'(vld_cnt), 32'd4);
    check("hunt_data", 32'(bus.accel_data), 32'h0102);

    // Bad high-byte flag bits.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h41, 1'b1);
    check("badhi_err", 32'(err_cnt), 32'd1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check("badhi_vld", 32'(vld_cnt), 32'd4);
    send_frame(8'hA5, 8'h00, 8'h07);
    repeat (20) @(negedge clk);
    check("after_badhi_vld", 32'(vld_cnt), 32'd5);
    check("after_badhi_data", 32'(bus.accel_data), 32'h0007);

    // Glitch mid-frame, then a low byte with a broken stop bit.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (4) @(negedge clk);
    bus.RX_A = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy", 32'(bus.rx_busy), 32'h1);
    bus.RX_A = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_idle", 32'(bus.rx_busy), 32'h0);
    check("glitch_err", 32'(err_cnt), 32'd1);
    send_byte(8'h02, 1'b0);
    repeat (20) @(negedge clk);
    check("stop_err", 32'(err_cnt), 32'd2);
    check("stop_vld", 32'(vld_cnt), 32'd5);
    send_frame(8'hA5, 8'h00, 8'h09);
    repeat (20) @(negedge clk);
    check("resync_vld", 32'(vld_cnt), 32'd6);
    check("resync_data", 32'(bus.accel_data), 32'h0009);
    check("resync_err", 32'(err_cnt), 32'd2);

    // Reset in the middle of a byte.
    send_byte(8'hA5, 1'b1);
    bus.RX_A = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_busy", 32'(bus.rx_busy), 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_data", 32'(bus.accel_data), 32'h0);
    check("mid_rst_vld", 32'(bus.accel_vld), 32'h0);
    check("mid_rst_err", 32'(bus.frm_err), 32'h0);
    check("mid_rst_busy", 32'(bus.rx_busy), 32'h0);
    bus.RX_A = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(8'hA5, 8'h1A, 8'h2B);
    repeat (20) @(negedge clk);
    check("post_rst_vld", 32'(vld_cnt), 32'd7);
    check("post_rst_data", 32'(bus.accel_data), 32'h1A2B);

    // Stall inside a partial frame.
    err_base = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
`ifdef ACCEL_FRM_TMO_EN
    for (int i = 0; i < 20 * Bd + 40; i++) begin
      if (err_cnt != err_base) break;
      @(negedge clk);
    end
    check("tmo_err", 32'(err_cnt), 32'(err_base + 1));
    send_byte(8'h34, 1'b1);
    repeat (20) @(negedge clk);
    check("tmo_orphan_vld", 32'(vld_cnt), 32'd7);
    send_frame(8'hA5, 8'h00, 8'h34);
    repeat (20) @(negedge clk);
    check("tmo_next_vld", 32'(vld_cnt), 32'd8);
    check("tmo_next_data", 32'(bus.accel_data), 32'h0034);
`else
    repeat (20 * Bd + 80) @(negedge clk);
    check("stall_err", 32'(err_cnt), 32'(err_base));
    send_byte(8'h34, 1'b1);
    repeat (20) @(negedge clk);
    check("stall_vld", 32'(vld_cnt), 32'd8);
    check("stall_data", 32'(bus.accel_data), 32'h1234);
`endif

    check("data_stable", 32'(bad_data_cnt), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
